// File: rtl/cva6_lsu_issue_stage.sv
// In-order load/store issue stage in front of the CVA6 LSU.
// Spaced single-cycle issue pulses, store commit timers, pending-store throttle.
module cva6_lsu_issue_stage #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned INSTR_W     = 32,
    parameter int unsigned COMMIT_LAT  = 2,
    parameter int unsigned MAX_PEND_ST = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       enq_valid_i,
    input  logic [INSTR_W-1:0]         enq_instr_i,
    input  logic                       enq_is_load_i,
    output logic                       enq_ready_o,
    input  logic                       flush_i,
    input  logic                       lsu_ready_i,
    input  logic                       store_done_i,
    output logic [INSTR_W-1:0]         instr_o,
    output logic                       is_load_o,
    output logic                       instr_valid_o,
    output logic                       store_commit_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [2:0]                 pend_st_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned NT = MAX_PEND_ST;

    logic [INSTR_W-1:0] mem_instr [DEPTH];
    logic [DEPTH-1:0]   mem_ld;
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      wr_ptr;
    logic [CW-1:0]      count;
    logic [2:0]         pend_st;
    logic [2:0]         tmr_cnt [NT];
    logic [NT-1:0]      tmr_act;
    logic [NT-1:0]      alloc;
    logic               found;
    logic               push;
    logic               issue;
    logic               head_ld;
    logic               st_issue;
    logic               st_dec;

    assign enq_ready_o = rst_ni && (count < CW'(DEPTH));
    assign push        = enq_valid_i && enq_ready_o && !flush_i;
    assign head_ld     = mem_ld[rd_ptr];
    assign issue       = (count != '0) && lsu_ready_i && !instr_valid_o
                         && !flush_i
                         && (head_ld || (pend_st < 3'(MAX_PEND_ST)));
    assign st_issue    = issue && !head_ld;
    assign st_dec      = store_done_i && (pend_st != '0);
    assign count_o     = count;
    assign pend_st_o   = pend_st;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_instr[wr_ptr] <= enq_instr_i;
            mem_ld[wr_ptr]    <= enq_is_load_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            pend_st       <= '0;
            instr_valid_o <= 1'b0;
            instr_o       <= '0;
            is_load_o     <= 1'b0;
        end else begin
            if (flush_i) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (issue) rd_ptr <= rd_ptr + AW'(1);
                if (push && !issue) count <= count + CW'(1);
                else if (issue && !push) count <= count - CW'(1);
            end
            instr_valid_o <= issue;
            instr_o       <= issue ? mem_instr[rd_ptr] : '0;
            is_load_o     <= issue && head_ld;
            if (st_issue && !st_dec) pend_st <= pend_st + 3'd1;
            else if (st_dec && !st_issue) pend_st <= pend_st - 3'd1;
        end
    end

    // a new store takes the lowest idle commit timer
    always_comb begin
        alloc = '0;
        found = 1'b0;
        for (int i = 0; i < int'(NT); i++) begin
            if (st_issue && !tmr_act[i] && !found) begin
                alloc[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tmr_act        <= '0;
            store_commit_o <= 1'b0;
            for (int i = 0; i < int'(NT); i++) tmr_cnt[i] <= '0;
        end else begin
            store_commit_o <= 1'b0;
            for (int i = 0; i < int'(NT); i++) begin
                if (alloc[i]) begin
                    tmr_act[i] <= 1'b1;
                    tmr_cnt[i] <= 3'(COMMIT_LAT);
                end else if (tmr_act[i]) begin
                    if (tmr_cnt[i] == 3'd1) begin
                        tmr_act[i]     <= 1'b0;
                        tmr_cnt[i]     <= '0;
                        store_commit_o <= 1'b1;
                    end else begin
                        tmr_cnt[i] <= tmr_cnt[i] - 3'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cva6_lsu_issue_stage.sv
// Bench for cva6_lsu_issue_stage: queue-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_cva6_lsu_issue_stage;

    localparam int DEPTH = 4;
    localparam int W     = 32;
    localparam int LAT   = 2;
    localparam int MAXP  = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enq_valid;
    logic [W-1:0] enq_instr;
    logic         enq_is_load;
    logic         enq_ready;
    logic         flush;
    logic         lsu_ready;
    logic         store_done;
    logic [W-1:0] instr;
    logic         is_load;
    logic         instr_valid;
    logic         store_commit;
    logic [2:0]   count;
    logic [2:0]   pend;

    always #5 clk = ~clk;

    cva6_lsu_issue_stage #(
        .DEPTH(DEPTH), .INSTR_W(W), .COMMIT_LAT(LAT), .MAX_PEND_ST(MAXP)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .enq_valid_i(enq_valid), .enq_instr_i(enq_instr),
        .enq_is_load_i(enq_is_load), .enq_ready_o(enq_ready),
        .flush_i(flush), .lsu_ready_i(lsu_ready),
        .store_done_i(store_done),
        .instr_o(instr), .is_load_o(is_load),
        .instr_valid_o(instr_valid), .store_commit_o(store_commit),
        .count_o(count), .pend_st_o(pend)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] ins;
        logic         ld;
    } ent_t;

    ent_t         q[$];
    int           commit_at[$];
    int           cyc    = 0;
    int           m_pend = 0;
    int           nxt_pend;
    bit           m_ok   = 0;
    bit           iss;
    bit           acc;
    bit           ec;
    ent_t         h;
    logic         m_valid = 0;
    logic         m_ld    = 0;
    logic [W-1:0] m_instr = '0;

    // reference model: a queue of entries and absolute commit cycles
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            q.delete();
            commit_at.delete();
            m_pend  = 0;
            m_valid = 0;
            m_instr = '0;
            m_ld    = 0;
            m_ok    = 1;
        end else begin
            iss = 0;
            if (q.size() > 0)
                iss = lsu_ready && !m_valid && !flush
                      && (q[0].ld || m_pend < MAXP);
            acc = enq_valid && (q.size() < DEPTH) && !flush;
            nxt_pend = m_pend;
            if (iss && !q[0].ld) nxt_pend++;
            if (store_done && m_pend > 0) nxt_pend--;
            if (iss) begin
                h       = q.pop_front();
                m_valid = 1;
                m_instr = h.ins;
                m_ld    = h.ld;
                if (!h.ld) commit_at.push_back(cyc + LAT);
            end else begin
                m_valid = 0;
                m_instr = '0;
                m_ld    = 0;
            end
            if (flush) q.delete();
            if (acc) q.push_back('{enq_instr, enq_is_load});
            m_pend = nxt_pend;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            ec = (commit_at.size() > 0) && (commit_at[0] == cyc);
            chk("m_instr_valid", instr_valid, m_valid);
            chk("m_instr", instr, m_instr);
            chk("m_is_load", is_load, m_ld);
            chk("m_store_commit", store_commit, ec);
            chk("m_enq_ready", enq_ready, rst_n && (q.size() < DEPTH));
            chk("m_count", count, q.size());
            chk("m_pend_st", pend, m_pend);
            if (ec) void'(commit_at.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (instr_valid !== 1'b1 && n < 20);
        total++;
        if (instr_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s timeout: got valid=%b want 1", nm, instr_valid);
        end
    endtask

    int np;
    int nc;

    initial begin
        rst_n       = 0;
        enq_valid   = 0;
        enq_instr   = '0;
        enq_is_load = 0;
        flush       = 0;
        lsu_ready   = 0;
        store_done  = 0;
        step();
        step();
        chk("rst_enq_ready", enq_ready, 0);
        chk("rst_count", count, 0);
        chk("rst_valid", instr_valid, 0);
        rst_n     = 1;
        lsu_ready = 1;
        step();

        // single load, two-cycle enqueue-to-issue latency
        enq_valid   = 1;
        enq_instr   = 32'hcad;
        enq_is_load = 1;
        step();
        enq_valid = 0;
        chk("ld_early_valid", instr_valid, 0);
        chk("ld_count1", count, 1);
        step();
        chk("ld_valid", instr_valid, 1);
        chk("ld_instr", instr, 32'hcad);
        chk("ld_is_load", is_load, 1);
        chk("ld_count0", count, 0);
        step();
        chk("ld_valid_off", instr_valid, 0);
        chk("ld_instr_zero", instr, 0);
        chk("ld_no_commit", store_commit, 0);

        // single store with commit two cycles after the pulse
        enq_valid   = 1;
        enq_is_load = 0;
        step();
        enq_valid = 0;
        step();
        chk("st_valid", instr_valid, 1);
        chk("st_is_load", is_load, 0);
        chk("st_pend1", pend, 1);
        step();
        chk("st_commit_t1", store_commit, 0);
        step();
        chk("st_commit_t2", store_commit, 1);
        chk("st_pend_hold", pend, 1);
        step();
        chk("st_commit_t3", store_commit, 0);
        store_done = 1;
        step();
        store_done = 0;
        chk("st_pend0", pend, 0);

        // pending-store throttle
        np = 0;
        for (int i = 0; i < 4; i++) begin
            enq_valid   = 1;
            enq_instr   = 32'h200 + i;
            enq_is_load = (i == 3);
            step();
            if (instr_valid) np++;
        end
        enq_valid = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (instr_valid) np++;
        end
        chk("thr_pulses", np, 2);
        chk("thr_count", count, 2);
        chk("thr_pend", pend, 2);
        store_done = 1;
        step();
        store_done = 0;
        chk("thr_still_blocked", instr_valid, 0);
        step();
        chk("thr_st3_valid", instr_valid, 1);
        chk("thr_st3_instr", instr, 32'h202);
        chk("thr_st3_is_load", is_load, 0);
        step();
        chk("thr_gap", instr_valid, 0);
        step();
        chk("thr_ld_valid", instr_valid, 1);
        chk("thr_ld_instr", instr, 32'h203);
        chk("thr_ld_is_load", is_load, 1);
        store_done = 1;
        step();
        step();
        store_done = 0;
        chk("thr_pend0", pend, 0);
        chk("thr_count0", count, 0);

        // full queue refuses the fifth push, then drains in order
        lsu_ready = 0;
        for (int i = 0; i < 5; i++) begin
            enq_valid   = 1;
            enq_instr   = 32'h300 + i;
            enq_is_load = 1;
            step();
        end
        enq_valid = 0;
        chk("full_count", count, 4);
        chk("full_enq_ready", enq_ready, 0);
        lsu_ready = 1;
        for (int i = 0; i < 4; i++) begin
            wait_valid("drain");
            chk("drain_instr", instr, 32'h300 + i);
        end
        for (int r = 0; r < 2; r++) begin
            lsu_ready = 0;
            for (int k = 0; k < 4; k++) begin
                enq_valid   = 1;
                enq_instr   = 32'h400 + r * 4 + k;
                enq_is_load = 1;
                step();
            end
            enq_valid = 0;
            lsu_ready = 1;
            for (int k = 0; k < 4; k++) begin
                wait_valid("wrap");
                chk("wrap_instr", instr, 32'h400 + r * 4 + k);
            end
        end
        step();
        step();
        chk("wrap_count0", count, 0);

        // flush with a same-cycle push and a ready head
        enq_valid   = 1;
        enq_instr   = 32'h500;
        enq_is_load = 0;
        step();
        enq_valid = 0;
        wait_valid("fl_store");
        chk("fl_store_instr", instr, 32'h500);
        lsu_ready   = 0;
        enq_valid   = 1;
        enq_instr   = 32'h501;
        enq_is_load = 1;
        step();
        chk("fl_count1", count, 1);
        flush     = 1;
        enq_instr = 32'h502;
        lsu_ready = 1;
        step();
        flush     = 0;
        enq_valid = 0;
        chk("fl_count0", count, 0);
        chk("fl_no_issue", instr_valid, 0);
        chk("fl_commit", store_commit, 1);
        step();
        chk("fl_still_idle", instr_valid, 0);
        chk("fl_commit_off", store_commit, 0);
        store_done = 1;
        step();
        store_done = 0;
        chk("fl_pend0", pend, 0);

        // reset while a store commit is in flight
        enq_valid   = 1;
        enq_instr   = 32'h600;
        enq_is_load = 0;
        step();
        enq_valid = 0;
        wait_valid("rs_store");
        step();
        rst_n = 0;
        #1;
        chk("rs_enq_ready_comb", enq_ready, 0);
        step();
        chk("rs_commit", store_commit, 0);
        chk("rs_valid", instr_valid, 0);
        chk("rs_instr", instr, 0);
        chk("rs_is_load", is_load, 0);
        chk("rs_count", count, 0);
        chk("rs_pend", pend, 0);
        chk("rs_enq_ready", enq_ready, 0);
        nc = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            rst_n = 1;
            if (store_commit) nc++;
        end
        chk("rs_no_commit", nc, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
